vdb_mem_responder: RTL and testbench
====================================

# vdb_mem_responder

Vector-database memory responder for RAG-CSD. It is the serving end of the `mem_rd_en`/`mem_rd_addr`/`mem_rd_data`/`mem_rd_valid` read interface used by the retrieval engines. It holds the DB header beats and the vector beats in an internal dual-port beat RAM, which the host loads through a write port. It returns one `BUS_WIDTH` beat per accepted address with a fixed, parameterised latency.

## Interface
Parameters:
- `BUS_WIDTH`, 512: beat width in bits; must be a power of two, at least 32.
- `DEPTH_BEATS`, 4096: number of RAM beats; must be a power of two.
- `READ_LATENCY`, 2: RAM access cycles; must be at least 1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: clock.
- `rst_n`  in  1: synchronous active-low reset.
- `mem_rd_en`  in  1: read request level from the initiator.
- `mem_rd_addr`  in  32: byte address.
- `mem_rd_data`  out  `BUS_WIDTH`: returned beat.
- `mem_rd_valid`  out  1: one-cycle pulse; `mem_rd_data` is valid in that cycle.
- `host_wr_en`  in  1: RAM write strobe.
- `host_wr_beat`  in  32: beat index to write.
- `host_wr_data`  in  `BUS_WIDTH`: beat data to write.
- `rd_busy`  out  1: high while a beat is in flight (FETCH or RESP).
- `beats_served`  out  32: count of `mem_rd_valid` pulses; wraps modulo 2^32.
- `err_oob`  out  1: sticky out-of-range flag; present only with `VDB_RESP_OOB_EN`.

## Operation
- Address decode:
  - beat index = `mem_rd_addr >> log2(BUS_WIDTH/8)`; low offset bits are ignored, so unaligned addresses round down.
  - Beats 0..3 hold the header, in order: db_size, db_addr_start, vector_stride, metadata_addr_start. Each value sits in bits [31:0] of its beat. The host writes these beats like any other beat; the block attaches no special meaning to them.
- State machine:
  - IDLE: if `mem_rd_en`=1, latch the beat index and go to FETCH with the latency counter set to `READ_LATENCY`-1.
  - FETCH: count down each cycle. At 0, go to RESP and load `mem_rd_data`.
  - RESP: `mem_rd_valid`=1 for this cycle only; increment `beats_served`; go to IDLE.
- Once a beat is latched it is always delivered. Dropping `mem_rd_en` during FETCH does not cancel it; the initiator ignores the pulse.
- IDLE samples `mem_rd_addr` again in the cycle after RESP, so the initiator's post-valid address increment is honoured. A stale address is never served twice.
- Host write in the same cycle as a RAM read of the same beat: the read returns the old data (read-first). Writes to indices ≥ `DEPTH_BEATS` are dropped.
- `mem_rd_data` holds its last value between pulses.

## Timing
- `mem_rd_en` sampled high at edge T → `mem_rd_valid` high in the cycle after edge T+`READ_LATENCY`+1.
- Sustained throughput: one beat per `READ_LATENCY`+2 cycles.
- Reset values: `mem_rd_valid`=0, `mem_rd_data`=0, `rd_busy`=0, `beats_served`=0, `err_oob`=0, state=IDLE.
- Reset mid-beat: the in-flight beat is discarded and no valid pulse is produced. RAM contents are not cleared.
- `beats_served` at 32'hFFFF_FFFF plus one pulse → 0.

## Configuration
- `VDB_RESP_OOB_EN` defined:
  - A latched beat index ≥ `DEPTH_BEATS` returns all-zero data and sets `err_oob`.
  - `err_oob` stays set until reset.
- `VDB_RESP_OOB_EN` undefined:
  - The beat index is truncated to log2(`DEPTH_BEATS`) bits, so out-of-range reads alias into the RAM.
  - `err_oob` does not exist.
- In both builds the valid pulse and latency are unchanged.

## Test plan
- Header read, `READ_LATENCY`=2:
  - Stimulus: load beats 0..3 with 10, 0x100, 0x600, 0x8000; initiator reads addresses 0x0, 0x40, 0x80, 0xC0, advancing on valid.
  - Response: 4 pulses, each 3 cycles after its sample, data[31:0] = 10, 0x100, 0x600, 0x8000; `beats_served`=4.
- Unaligned address:
  - Stimulus: read 0x7F.
  - Response: beat 1 is returned.
- Abort:
  - Stimulus: `mem_rd_en` drops one cycle after sampling.
  - Response: exactly one valid pulse, then IDLE; no further pulses.
- Write/read collision:
  - Stimulus: beat 5 = A; host writes B to beat 5 in the same cycle as the RAM read of beat 5.
  - Response: A is returned; a re-read returns B.
- Reset mid-beat:
  - Stimulus: assert `rst_n`=0 during FETCH.
  - Response: no valid pulse; all outputs at their reset values; a RAM re-read returns the preloaded data.
- `VDB_RESP_OOB_EN`, `DEPTH_BEATS`=4096:
  - Stimulus: read beat 4096.
  - Response: zero data and `err_oob`=1, sticky. Without the macro, the same read returns beat 0.

Source files
------------

// File: rtl/vdb_mem_responder.sv
// vdb_mem_responder: serving end of the retrieval engines' beat-read interface.
// Holds DB header and vector beats in a dual-port beat RAM loaded by the host,
// and returns one BUS_WIDTH beat per accepted address after a fixed latency.
// Optional build macro VDB_RESP_OOB_EN: out-of-range reads return zero data
// and raise the sticky err_oob flag instead of aliasing into the RAM.
module vdb_mem_responder #(
  parameter int BUS_WIDTH    = 512,
  parameter int DEPTH_BEATS  = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_rd_en,
  input  logic [31:0]          mem_rd_addr,
  output logic [BUS_WIDTH-1:0] mem_rd_data,
  output logic                 mem_rd_valid,
  input  logic                 host_wr_en,
  input  logic [31:0]          host_wr_beat,
  input  logic [BUS_WIDTH-1:0] host_wr_data,
  output logic                 rd_busy,
  output logic [31:0]          beats_served
`ifdef VDB_RESP_OOB_EN
  ,
  output logic                 err_oob
`endif
);

  localparam int OFF = $clog2(BUS_WIDTH / 8);
  localparam int AW  = $clog2(DEPTH_BEATS);
  localparam int CW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [BUS_WIDTH-1:0] ram [DEPTH_BEATS];
  logic [BUS_WIDTH-1:0] ram_q;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic          oob_reg, oob_next;
  logic [31:0]   beat_full;
  logic          ram_rd;

  // Byte address to beat index; the low offset bits are simply dropped.
  assign beat_full = mem_rd_addr >> OFF;

  // The single RAM access of a beat happens on the last FETCH cycle.
  assign ram_rd  = (state_reg == ST_FETCH) && (cnt_reg == '0);
  assign rd_busy = (state_reg != ST_IDLE);

`ifdef VDB_RESP_OOB_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_rd_addr[OFF-1:0];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_rd_addr[OFF-1:0], beat_full[31:AW]};
`endif

  // Beat RAM: host write port plus registered read; read-first on collision.
  always_ff @(posedge clk) begin
    if (host_wr_en && (host_wr_beat < 32'(DEPTH_BEATS)))
      ram[host_wr_beat[AW-1:0]] <= host_wr_data;
    if (ram_rd)
      ram_q <= ram[idx_reg];
  end

  // Next-state logic: latch a request in IDLE, count down in FETCH, answer in RESP.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    oob_next   = oob_reg;
    case (state_reg)
      ST_IDLE: begin
        if (mem_rd_en) begin
          state_next = ST_FETCH;
          cnt_next   = CW'(READ_LATENCY - 1);
          idx_next   = beat_full[AW-1:0];
`ifdef VDB_RESP_OOB_EN
          oob_next   = (beat_full >= 32'(DEPTH_BEATS));
`else
          oob_next   = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (cnt_reg == '0) state_next = ST_RESP;
        else               cnt_next   = cnt_reg - CW'(1);
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control and output registers; reset discards any beat in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      oob_reg      <= 1'b0;
      mem_rd_valid <= 1'b0;
      mem_rd_data  <= '0;
      beats_served <= '0;
`ifdef VDB_RESP_OOB_EN
      err_oob      <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      oob_reg      <= oob_next;
      mem_rd_valid <= (state_reg == ST_RESP);
      if (state_reg == ST_RESP) begin
        mem_rd_data  <= oob_reg ? '0 : ram_q;
        beats_served <= beats_served + 32'd1;
`ifdef VDB_RESP_OOB_EN
        if (oob_reg) err_oob <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vdb_mem_responder.sv
// tb_vdb_mem_responder: randomized scoreboard bench for vdb_mem_responder.
// A driver issues reads and pushes expected beats from a beat-array model;
// a monitor pops and compares on every mem_rd_valid pulse.
module tb_vdb_mem_responder;

  localparam int BW  = 512;
  localparam int RL  = 2;
  localparam int NB  = 64;   // beats preloaded and used by the model

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_rd_en;
  logic [31:0]   mem_rd_addr;
  logic [BW-1:0] mem_rd_data;
  logic          mem_rd_valid;
  logic          host_wr_en;
  logic [31:0]   host_wr_beat;
  logic [BW-1:0] host_wr_data;
  logic          rd_busy;
  logic [31:0]   beats_served;
`ifdef VDB_RESP_OOB_EN
  logic          err_oob;
`endif

  vdb_mem_responder #(.BUS_WIDTH(BW), .DEPTH_BEATS(4096), .READ_LATENCY(RL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .host_wr_en   (host_wr_en),
    .host_wr_beat (host_wr_beat),
    .host_wr_data (host_wr_data),
    .rd_busy      (rd_busy),
    .beats_served (beats_served)
`ifdef VDB_RESP_OOB_EN
    ,
    .err_oob      (err_oob)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] model_mem [NB];
  int            total = 0;
  int            bad = 0;
  int            issued = 0;

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] v;
    for (int k = 0; k < BW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: beat = byte address / 64; out-of-range either zero or aliased.
  function automatic logic [BW-1:0] model_read(int unsigned addr);
    int unsigned idx;
    idx = addr / (BW / 8);
`ifdef VDB_RESP_OOB_EN
    if (idx >= 4096) return '0;
`endif
    return model_mem[(idx % 4096) % NB];
  endfunction

  task automatic check(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(int unsigned addr);
    exp_t e;
    mem_rd_en   = 1'b1;
    mem_rd_addr = addr;
    e.data = model_read(addr);
    e.due  = cyc + RL + 2;
    exp_q.push_back(e);
    issued++;
    $display("issue addr=%08h due=%0d", addr, e.due);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_rd_valid && n < 20);
    if (!mem_rd_valid) begin
      total++;
      bad++;
      $display("FAIL valid_timeout: got no pulse expected one within 20 cycles");
    end
  endtask

  task automatic host_write(int unsigned beat, logic [BW-1:0] data);
    host_wr_en   = 1'b1;
    host_wr_beat = beat;
    host_wr_data = data;
    @(negedge clk);
    host_wr_en   = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_rd_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got pulse at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("resp cycle=%0d data[31:0]=%08h", cyc, mem_rd_data[31:0]);
          check("rd_data", mem_rd_data, e.data);
          check("rd_latency", cyc, e.due);
        end
      end
    end
  end

  initial begin
    logic [BW-1:0] a_val, b_val;
    logic [31:0]   hdr [4];
    int            r;
    hdr[0] = 32'd10; hdr[1] = 32'h100; hdr[2] = 32'h600; hdr[3] = 32'h8000;

    rst_n = 1'b0; mem_rd_en = 1'b0; mem_rd_addr = '0;
    host_wr_en = 1'b0; host_wr_beat = '0; host_wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", mem_rd_valid, 0);
    check("rst_data", mem_rd_data, 0);
    check("rst_busy", rd_busy, 0);
    check("rst_served", beats_served, 0);
    rst_n = 1'b1;

    // Preload model and RAM; beats 0..3 carry the header values.
    for (int i = 0; i < NB; i++) begin
      model_mem[i] = rand_beat();
      if (i < 4) model_mem[i][31:0] = hdr[i];
      host_write(i, model_mem[i]);
    end
    // Write beyond the RAM must be dropped, not alias onto beat 7.
    host_write(4096 + 7, rand_beat());

    // Header read, advancing the address on each valid.
    for (int i = 0; i < 4; i++) begin
      issue(i * 64);
      wait_valid();
      check("hdr_word", mem_rd_data[31:0], hdr[i]);
    end
    mem_rd_en = 1'b0;
    @(negedge clk);
    check("served_after_hdr", beats_served, 4);

    // Unaligned address rounds down to beat 1; data then holds.
    issue(32'h7F);
    wait_valid();
    mem_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("data_hold", mem_rd_data, model_mem[1]);

    // Abort: request dropped after sampling still yields exactly one pulse.
    issue(32'h100);
    @(negedge clk);
    mem_rd_en = 1'b0;
    wait_valid();
    repeat (8) @(negedge clk);
    check("abort_idle_busy", rd_busy, 0);

    // Dropped out-of-range write left beat 7 intact.
    issue(7 * 64);
    wait_valid();
    mem_rd_en = 1'b0;

    // Read/write collision on beat 5: old data, then new data on re-read.
    a_val = model_mem[5];
    b_val = rand_beat();
    @(negedge clk);
    issue(5 * 64);
    @(negedge clk);
    mem_rd_en = 1'b0;
    @(negedge clk);
    model_mem[5] = b_val;
    host_write(5, b_val);
    wait_valid();
    check("collision_old", mem_rd_data, a_val);
    issue(5 * 64);
    wait_valid();
    mem_rd_en = 1'b0;

    // Out-of-range read of beat 4096.
    @(negedge clk);
    issue(4096 * 64);
    wait_valid();
    mem_rd_en = 1'b0;
`ifdef VDB_RESP_OOB_EN
    @(negedge clk);
    check("err_oob_set", err_oob, 1);
    issue(2 * 64);
    wait_valid();
    mem_rd_en = 1'b0;
    @(negedge clk);
    check("err_oob_sticky", err_oob, 1);
`endif

    // Randomized reads with random hold or gap between requests.
    for (int n = 0; n < 24; n++) begin
      issue($urandom_range(0, NB * 64 - 1));
      wait_valid();
      if ($urandom_range(0, 1) == 1) begin
        mem_rd_en = 1'b0;
        r = $urandom_range(0, 3);
        repeat (r) @(negedge clk);
      end
    end
    mem_rd_en = 1'b0;
    repeat (4) @(negedge clk);
    check("served_total", beats_served, issued);

    // Reset mid-beat: no pulse, outputs back to reset values, RAM intact.
    mem_rd_en = 1'b1;
    mem_rd_addr = 6 * 64;
    @(negedge clk);
    mem_rd_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", mem_rd_valid, 0);
    check("midrst_data", mem_rd_data, 0);
    check("midrst_busy", rd_busy, 0);
    check("midrst_served", beats_served, 0);
`ifdef VDB_RESP_OOB_EN
    check("midrst_err_oob", err_oob, 0);
`endif
    rst_n = 1'b1;
    issued = 0;
    repeat (8) @(negedge clk);
    issue(6 * 64);
    wait_valid();
    mem_rd_en = 1'b0;
    repeat (4) @(negedge clk);
    check("served_after_rst", beats_served, issued);

    // Drain: everything expected must have been delivered.
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    check("pending_expect", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
